fpga_status_led_sequencer: RTL and testbench

//  Owns the board tri-colour LED (gpio[22:20]) on the FPGA wrapper and arbitrates it between

---
 rtl/fpga_status_led_sequencer.sv | 138 +++++++++++++
 tb/tb_fpga_status_led_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_status_led_sequencer.sv
// Tri-colour status LED owner: boot indication, heartbeat, SoC GPIO pass-through and sticky exit code.
// Optional build macro STATUS_LED_PWM_EN adds a global brightness PWM on the final LED drive.
//   state       | meaning
//   S_BOOT      | solid blue for BOOT_CYCLES after reset
//   S_RUN       | SoC-owned colours, green heartbeat otherwise
//   S_DONE_PASS | exit value 0 latched, solid green
//   S_DONE_FAIL | non-zero exit latched, red flash code
module fpga_status_led_sequencer #(
  parameter int BOOT_CYCLES = 125_000_000,
  parameter int BLINK_DIV_W = 25,
  parameter int PWM_W       = 8
) (
  input  logic             clk_gen,
  input  logic             rst_n,
  input  logic             exit_valid_i,
  input  logic [31:0]      exit_value_i,
  input  logic             clear_i,
  input  logic [2:0]       soc_led_i,
  input  logic [2:0]       soc_led_oe_i,
  input  logic [PWM_W-1:0] brightness_i,
  output logic [2:0]       led_o,
  output logic             done_o,
  output logic [31:0]      exit_code_o
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_DONE_PASS, S_DONE_FAIL} state_t;

  state_t                 state_q, state_d;
  logic [BOOT_W-1:0]      boot_cnt_q;
  logic [BLINK_DIV_W-1:0] presc_q;
  logic                   tick;
  logic                   hb_q;
  logic [5:0]             flash_ph_q;
  logic [4:0]             flash_n;
  logic [5:0]             flash_on_end;
  logic [5:0]             flash_last;
  logic                   flash_red;
  logic                   exit_take;
  logic                   fail_entry;
  logic [2:0]             led_pre;
  logic                   led_gate;

  assign tick       = (presc_q == '1);
  assign exit_take  = exit_valid_i && (state_q == S_BOOT || state_q == S_RUN);
  assign fail_entry = (state_d == S_DONE_FAIL) && (state_q != S_DONE_FAIL);

  // Flash frame: N on/off pairs followed by four dark half-periods; a zero nibble flashes 16 times.
  assign flash_n      = (exit_code_o[3:0] == 4'd0) ? 5'd16 : {1'b0, exit_code_o[3:0]};
  assign flash_on_end = {flash_n, 1'b0};
  assign flash_last   = flash_on_end + 6'd3;
  assign flash_red    = (flash_ph_q < flash_on_end) && !flash_ph_q[0];

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: begin
        if (exit_valid_i)              state_d = (exit_value_i == 32'd0) ? S_DONE_PASS : S_DONE_FAIL;
        else if (boot_cnt_q == BOOT_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (exit_valid_i) state_d = (exit_value_i == 32'd0) ? S_DONE_PASS : S_DONE_FAIL;
      end
      S_DONE_PASS, S_DONE_FAIL: begin
        if (clear_i) state_d = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    led_pre = 3'b000;
    done_o  = 1'b0;
    case (state_q)
      S_BOOT: led_pre = 3'b100;
      S_RUN: begin
        led_pre[0] = soc_led_oe_i[0] ? soc_led_i[0] : 1'b0;
        led_pre[1] = soc_led_oe_i[1] ? soc_led_i[1] : hb_q;
        led_pre[2] = soc_led_oe_i[2] ? soc_led_i[2] : 1'b0;
      end
      S_DONE_PASS: begin
        led_pre = 3'b010;
        done_o  = 1'b1;
      end
      S_DONE_FAIL: begin
        led_pre = {2'b00, flash_red};
        done_o  = 1'b1;
      end
      default: led_pre = 3'b000;
    endcase
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      boot_cnt_q  <= '0;
      presc_q     <= '0;
      hb_q        <= 1'b0;
      flash_ph_q  <= '0;
      exit_code_o <= '0;
    end else begin
      if (state_q == S_BOOT && boot_cnt_q != BOOT_LAST) boot_cnt_q <= boot_cnt_q + BOOT_W'(1);
      // Clearing on fail entry aligns the first flash half-period with the entry cycle.
      presc_q <= fail_entry ? '0 : presc_q + BLINK_DIV_W'(1);
      if (tick) hb_q <= ~hb_q;
      if (exit_take) exit_code_o <= exit_value_i;
      if (state_q != S_DONE_FAIL || state_d != S_DONE_FAIL) flash_ph_q <= '0;
      else if (tick) flash_ph_q <= (flash_ph_q == flash_last) ? 6'd0 : flash_ph_q + 6'd1;
    end
  end

`ifdef STATUS_LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q;

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) pwm_cnt_q <= '0;
    else        pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
  end

  assign led_gate = (pwm_cnt_q < brightness_i);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness_i;
  assign led_gate = 1'b1;
`endif

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) led_o <= 3'b000;
    else        led_o <= led_pre & {3{led_gate}};
  end

endmodule

// File: tb/tb_fpga_status_led_sequencer.sv
// Bench for fpga_status_led_sequencer: random stimulus against a time-based behavioural model.
module tb_fpga_status_led_sequencer;
  localparam int BC = 8;
  localparam int BW = 2;
  localparam int PW = 4;
  localparam int HP = 1 << BW;

  logic          clk_gen = 1'b0;
  logic          rst_n = 1'b1;
  logic          exit_valid_i = 1'b0;
  logic [31:0]   exit_value_i = '0;
  logic          clear_i = 1'b0;
  logic [2:0]    soc_led_i = '0;
  logic [2:0]    soc_led_oe_i = '0;
  logic [PW-1:0] brightness_i = '0;
  logic [2:0]    led_o;
  logic          done_o;
  logic [31:0]   exit_code_o;

  fpga_status_led_sequencer #(.BOOT_CYCLES(BC), .BLINK_DIV_W(BW), .PWM_W(PW)) dut (
    .clk_gen(clk_gen), .rst_n(rst_n), .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i),
    .clear_i(clear_i), .soc_led_i(soc_led_i), .soc_led_oe_i(soc_led_oe_i),
    .brightness_i(brightness_i), .led_o(led_o), .done_o(done_o), .exit_code_o(exit_code_o)
  );

  always #5 clk_gen = ~clk_gen;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 boot, 1 run, 2 pass, 3 fail; g counts cycles since reset release.
  int          m_mode = 0;
  int          g = 0;
  int          base = 0;
  int          fail_g = 0;
  bit          hb_m = 1'b0;
  logic [31:0] m_code = '0;
  logic [2:0]  exp_led = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_led();
    logic [2:0] v;
    int n, el, pos;
    v = 3'b000;
    case (m_mode)
      0: v = 3'b100;
      1: begin
        v[0] = soc_led_oe_i[0] ? soc_led_i[0] : 1'b0;
        v[1] = soc_led_oe_i[1] ? soc_led_i[1] : hb_m;
        v[2] = soc_led_oe_i[2] ? soc_led_i[2] : 1'b0;
      end
      2: v = 3'b010;
      default: begin
        n   = (m_code[3:0] == 4'd0) ? 16 : int'(m_code[3:0]);
        el  = g - fail_g - 1;
        pos = (el / HP) % (2 * n + 4);
        v[0] = (pos < 2 * n) && (pos % 2 == 0);
      end
    endcase
`ifdef STATUS_LED_PWM_EN
    if ((g % (1 << PW)) >= int'(brightness_i)) v = 3'b000;
`endif
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk_gen or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; g = 0; base = 0; fail_g = 0; hb_m = 1'b0; m_code = '0; exp_led = '0;
      end else begin
        exp_led = model_led();
        if (((g - base) % HP) == HP - 1) hb_m = ~hb_m;
        if (m_mode < 2 && exit_valid_i) begin
          m_code = exit_value_i;
          if (exit_value_i == 32'd0) m_mode = 2;
          else begin
            m_mode = 3; fail_g = g; base = g + 1;
          end
        end else if (m_mode >= 2 && clear_i) m_mode = 1;
        else if (m_mode == 0 && g == BC - 1) m_mode = 1;
        g++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_gen);
      if (chk_en) begin
        chk("led_o", 32'(led_o), 32'(exp_led));
        chk("done_o", 32'(done_o), (m_mode >= 2) ? 32'd1 : 32'd0);
        chk("exit_code_o", exit_code_o, m_code);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_gen);
  endtask

  task automatic rand_soc();
    soc_led_i    = 3'($urandom);
    soc_led_oe_i = 3'($urandom);
    brightness_i = PW'($urandom);
  endtask

  task automatic fire_exit(input logic [31:0] v);
    exit_valid_i = 1'b1; exit_value_i = v;
    cyc(1);
    exit_valid_i = 1'b0; exit_value_i = 32'($urandom);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    cyc(1);
    clear_i = 1'b0;
  endtask

  // Called right after fire_exit; counts red rising edges across one full flash frame.
  task automatic count_red(input int n, output int rises);
    logic prev;
    rises = 0;
    prev = led_o[0];
    for (int k = 1; k < HP * (2 * n + 4); k++) begin
      cyc(1);
      if (led_o[0] && !prev) rises++;
      prev = led_o[0];
    end
  endtask

  initial begin
    int rises;
    int highs;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    cyc(2);
    chk("reset_led", 32'(led_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_code", exit_code_o, 32'd0);
    rst_n = 1'b1;
    brightness_i = PW'(15);
    cyc(4);
`ifndef STATUS_LED_PWM_EN
    chk("boot_blue", 32'(led_o), 32'b100);
`endif
    cyc(30);

    soc_led_oe_i = 3'b001; soc_led_i = 3'b001;
    cyc(12);
    for (int i = 0; i < 40; i++) begin
      rand_soc();
      cyc(1);
    end

    soc_led_oe_i = 3'b000; brightness_i = PW'(15);
    fire_exit(32'd0);
    cyc(2);
`ifndef STATUS_LED_PWM_EN
    chk("pass_green", 32'(led_o), 32'b010);
`endif
    chk("pass_done", 32'(done_o), 32'd1);
    fire_exit(32'd5);
    cyc(3);
    chk("sticky_code", exit_code_o, 32'd0);

`ifdef STATUS_LED_PWM_EN
    brightness_i = PW'(4);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (led_o[1]) highs++;
    end
    chk("pwm_duty4", 32'(highs), 32'd4);
    brightness_i = PW'(0);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (led_o != 3'b000) highs++;
    end
    chk("pwm_dark", 32'(highs), 32'd0);
    brightness_i = PW'(15);
`endif

    pulse_clear();
    chk("clear_done", 32'(done_o), 32'd0);

    fire_exit(32'h13);
    count_red(3, rises);
`ifndef STATUS_LED_PWM_EN
    chk("red_pulses_3", 32'(rises), 32'd3);
`endif
    chk("code_13", exit_code_o, 32'h13);
    cyc(50);

    clear_i = 1'b1; exit_valid_i = 1'b1; exit_value_i = 32'd0;
    cyc(1);
    chk("clear_wins", 32'(done_o), 32'd0);
    clear_i = 1'b0;
    cyc(1);
    exit_valid_i = 1'b0;
    chk("reenter_done", 32'(done_o), 32'd1);
    chk("reenter_code", exit_code_o, 32'd0);

    pulse_clear();
    fire_exit(32'h20);
    count_red(16, rises);
`ifndef STATUS_LED_PWM_EN
    chk("red_pulses_16", 32'(rises), 32'd16);
`endif

    pulse_clear();
    fire_exit(32'h13);
    cyc(1);
`ifndef STATUS_LED_PWM_EN
    chk("flash_on", 32'(led_o), 32'b001);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("async_led", 32'(led_o), 32'd0);
    chk("async_done", 32'(done_o), 32'd0);
    chk("async_code", exit_code_o, 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(5);
`ifndef STATUS_LED_PWM_EN
    chk("reboot_blue", 32'(led_o), 32'b100);
`endif
    cyc(10);

    for (int i = 0; i < 1500; i++) begin
      rand_soc();
      exit_valid_i = ($urandom_range(0, 24) == 0);
      exit_value_i = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom);
      clear_i      = ($urandom_range(0, 59) == 0);
      cyc(1);
    end
    exit_valid_i = 1'b0; clear_i = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
